// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU/shifter/multiplier operation sequencer
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [5:0] funct,
  output logic       op_ready,
  input  logic       flush,
  output logic [5:0] sel_ctl,
  output logic       mul_start,
  output logic       mul_step,
  output logic       hilo_we,
  output logic [1:0] mux_sel,
  output logic       result_valid,
  output logic       illegal,
  output logic       busy
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WRHL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             xfer;

  // Ops that finish in one EXEC cycle and produce a result
  function automatic logic is_single(input logic [5:0] f);
    return (f == F_AND) || (f == F_OR) || (f == F_ADD) ||
           (f == F_SUB) || (f == F_SLT) || (f == F_SLL);
  endfunction

  // State register; reset drops straight to IDLE so no partial HiLo write survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Multiplier step counter: runs 0..MUL_CYCLES-1 in MUL, zero everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == S_MUL && !flush && cnt != CNT_LAST)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  // Capture funct only on a transfer; held for the whole operation and in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sel_ctl <= '0;
    else if (xfer) sel_ctl <= funct;
  end

  // Next-state and Moore outputs; flush overrides every transition including acceptance
  always_comb begin
    state_nxt    = state;
    op_ready     = (state == S_IDLE);
    busy         = (state != S_IDLE);
    xfer         = op_valid && (state == S_IDLE) && !flush;
    mul_start    = 1'b0;
    mul_step     = 1'b0;
    hilo_we      = 1'b0;
    mux_sel      = 2'b00;
    result_valid = 1'b0;
    illegal      = 1'b0;

    case (state)
      S_IDLE: begin
        if (xfer) state_nxt = (funct == F_MULTU) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_IDLE;
        if (is_single(sel_ctl)) begin
          result_valid = 1'b1;
          mux_sel      = (sel_ctl == F_SLL) ? 2'b01 : 2'b00;
        end else begin
          illegal = 1'b1;
        end
      end
      S_MUL: begin
        mul_step  = 1'b1;
        mul_start = (cnt == '0);
        if (cnt == CNT_LAST) state_nxt = S_WRHL;
      end
      S_WRHL: begin
        hilo_we      = 1'b1;
        mux_sel      = 2'b10;
        result_valid = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (flush) state_nxt = S_IDLE;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard testbench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [5:0] funct = 6'd0;
  logic       flush = 1'b0;
  logic       op_ready;
  logic [5:0] sel_ctl;
  logic       mul_start;
  logic       mul_step;
  logic       hilo_we;
  logic [1:0] mux_sel;
  logic       result_valid;
  logic       illegal;
  logic       busy;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
    .op_ready(op_ready), .flush(flush), .sel_ctl(sel_ctl),
    .mul_start(mul_start), .mul_step(mul_step), .hilo_we(hilo_we),
    .mux_sel(mux_sel), .result_valid(result_valid), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] f;
    logic [1:0] mux;
    logic       ill;
    logic       mul;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour derived from the opcode table; t is the acceptance edge
  function automatic exp_t model(input logic [5:0] f, input int t);
    exp_t e;
    e.f   = f;
    e.mul = (f == 6'd25);
    e.ill = !(f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd25});
    e.mux = e.mul ? 2'b10 : ((f == 6'd0) ? 2'b01 : 2'b00);
    e.cyc = e.mul ? t + 32 : t;
    return e;
  endfunction

  // Scoreboard consumer: every result/illegal/HiLo-write cycle must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (result_valid || illegal || hilo_we)) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output cyc=%0d rv=%b ill=%b hilo_we=%b sel_ctl=%0d required none",
                 cyc, result_valid, illegal, hilo_we, sel_ctl);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (cyc !== e.cyc) begin
          failures++;
          $display("FAIL latency funct=%0d got cyc=%0d required cyc=%0d", e.f, cyc, e.cyc);
        end
        checks++;
        if (sel_ctl !== e.f) begin
          failures++;
          $display("FAIL sel_ctl got %0d required %0d", sel_ctl, e.f);
        end
        checks++;
        if ({illegal, result_valid, hilo_we} !== {e.ill, !e.ill, e.mul}) begin
          failures++;
          $display("FAIL flags funct=%0d got ill/rv/we=%b%b%b required %b%b%b", e.f,
                   illegal, result_valid, hilo_we, e.ill, !e.ill, e.mul);
        end
        if (!e.ill) begin
          checks++;
          if (mux_sel !== e.mux) begin
            failures++;
            $display("FAIL mux_sel funct=%0d got %b required %b", e.f, mux_sel, e.mux);
          end
        end
      end
    end
  end

  // Wait for op_ready, transfer one op, optionally record its expected result
  task automatic send_op(input logic [5:0] f, input bit expect_res, output int t);
    int n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!op_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout funct=%0d got op_ready=0 required 1", f);
    end
    op_valid = 1'b1;
    funct    = f;
    @(posedge clk); #1;
    t = cyc;
    if (expect_res) sbq.push_back(model(f, t));
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({op_ready, busy, sel_ctl, mux_sel, mul_start, mul_step, hilo_we, result_valid, illegal}
        !== {1'b1, 1'b0, 6'd0, 2'b00, 5'b0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b busy=%b sel=%0d mux=%b pulses=%b%b%b%b%b required rdy=1 rest 0",
               op_ready, busy, sel_ctl, mux_sel, mul_start, mul_step, hilo_we, result_valid, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops();
    logic [5:0] tbl [6];
    int t;
    tbl = '{6'd32, 6'd36, 6'd37, 6'd34, 6'd42, 6'd0};
    foreach (tbl[i]) begin
      send_op(tbl[i], 1'b1, t);
      @(negedge clk);
      checks++;
      if ({busy, op_ready} !== 2'b10) begin
        failures++;
        $display("FAIL exec_busy funct=%0d got busy=%b rdy=%b required 1 0", tbl[i], busy, op_ready);
      end
      @(negedge clk);
      checks++;
      if ({busy, op_ready, result_valid} !== 3'b010) begin
        failures++;
        $display("FAIL exec_return funct=%0d got busy=%b rdy=%b rv=%b required 0 1 0",
                 tbl[i], busy, op_ready, result_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    op_valid = 1'b1;
    funct    = 6'd0;
    @(posedge clk); #1;
    t = cyc;
    sbq.push_back(model(6'd0, t));
    sbq.push_back(model(6'd34, t + 2));
    funct = 6'd34;
    checks++;
    if (op_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_not_ready got %b required 0", op_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_accept got busy=%b required 1", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal();
    int t;
    send_op(6'd63, 1'b1, t);
    @(negedge clk);
    checks++;
    if ({illegal, result_valid} !== 2'b10) begin
      failures++;
      $display("FAIL illegal_pulse got ill=%b rv=%b required 1 0", illegal, result_valid);
    end
    @(negedge clk);
    checks++;
    if ({illegal, op_ready} !== 2'b01) begin
      failures++;
      $display("FAIL illegal_return got ill=%b rdy=%b required 0 1", illegal, op_ready);
    end
  endtask

  task automatic test_multu();
    int t;
    logic [3:0] got;
    logic [3:0] req;
    send_op(6'd25, 1'b1, t);
    op_valid = 1'b1;
    funct    = 6'd32;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k == 32) op_valid = 1'b0;
      got = {mul_start, mul_step, hilo_we, op_ready};
      req = {k == 0, k <= 31, k == 32, k == 33};
      checks++;
      if (got !== req) begin
        failures++;
        $display("FAIL multu_seq k=%0d got start/step/we/rdy=%b required %b", k, got, req);
      end
      if (k <= 32) begin
        checks++;
        if (sel_ctl !== 6'd25) begin
          failures++;
          $display("FAIL multu_hold k=%0d got sel_ctl=%0d required 25", k, sel_ctl);
        end
      end
    end
  endtask

  task automatic test_flush();
    int t;
    op_valid = 1'b1;
    funct    = 6'd32;
    flush    = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if ({busy, op_ready} !== 2'b01) begin
      failures++;
      $display("FAIL flush_priority got busy=%b rdy=%b required 0 1", busy, op_ready);
    end
    send_op(6'd25, 1'b0, t);
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if ({busy, mul_step, mul_start} !== 3'b110) begin
      failures++;
      $display("FAIL flush_pre got busy/step/start=%b%b%b required 110", busy, mul_step, mul_start);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({busy, mul_step, hilo_we, result_valid, op_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL flush_abort got busy/step/we/rv/rdy=%b%b%b%b%b required 00001",
               busy, mul_step, hilo_we, result_valid, op_ready);
    end
    repeat (20) @(negedge clk);
    send_op(6'd25, 1'b1, t);
    repeat (34) @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int t;
    int hits = 0;
    send_op(6'd25, 1'b0, t);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({op_ready, busy, sel_ctl, mux_sel, mul_start, mul_step, hilo_we, result_valid, illegal}
        !== {1'b1, 1'b0, 6'd0, 2'b00, 5'b0}) begin
      failures++;
      $display("FAIL async_reset got rdy=%b busy=%b sel=%0d mux=%b pulses=%b%b%b%b%b required rdy=1 rest 0",
               op_ready, busy, sel_ctl, mux_sel, mul_start, mul_step, hilo_we, result_valid, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hilo_we || busy) hits++;
    end
    checks++;
    if (hits !== 0) begin
      failures++;
      $display("FAIL reset_no_hilo got %0d active cycles required 0", hits);
    end
    send_op(6'd32, 1'b1, t);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_illegal();
    test_multu();
    test_flush();
    test_reset_mid_mul();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
